// File: rtl/imem_pkg.sv
// Shared definitions for the instruction RAM controller and the fetch stage.
package imem_pkg;

  // Controller states
  localparam logic [0:0] IMEM_BOOT = 1'b0;
  localparam logic [0:0] IMEM_RUN  = 1'b1;

  // Byte address to RAM word index: drop the byte offset and keep aw index bits.
  function automatic logic [63:0] imem_word_idx(input logic [63:0] byte_addr,
                                                input int unsigned aw);
    return (byte_addr >> 2) & ((64'd1 << aw) - 64'd1);
  endfunction

endpackage

// File: rtl/imem_ctrl.sv
// Instruction RAM controller: boot loader streams words into the RAM, then the
// fetch stage owns it for one-cycle-latency reads.
// Optional feature macro: IMEM_CTRL_LOADER_EN (undefined: no loader, always in RUN).
module imem_ctrl
  import imem_pkg::*;
#(
  parameter int unsigned MP_WIDTH = 32,
  parameter int unsigned MP_DEPTH = 256,
  localparam int unsigned MP_AW = $clog2(MP_DEPTH)
) (
  input  logic                iclk,
  input  logic                irst_n,
  input  logic                ifetch_req,
  input  logic [MP_WIDTH-1:0] ifetch_addr,
  output logic                ofetch_rdy,
  output logic                ofetch_vld,
  output logic [MP_WIDTH-1:0] ofetch_data,
  output logic                ofetch_err,
  input  logic                iload_vld,
  input  logic [MP_WIDTH-1:0] iload_data,
  input  logic                iload_last,
  output logic                oload_rdy,
  output logic [MP_AW:0]      oload_cnt,
  input  logic                ireload,
  output logic                obooted,
  output logic                omem_en,
  output logic                omem_we,
  output logic [MP_AW-1:0]    omem_addr,
  output logic [MP_WIDTH-1:0] omem_wdata,
  input  logic [MP_WIDTH-1:0] imem_rdata
);

  logic             fetch_acc;
  logic             load_acc;
  logic [MP_AW-1:0] load_idx;
  logic [MP_AW-1:0] fetch_idx;
  logic             fetch_vld_q;
  logic             fetch_err_q;

  assign fetch_acc = ifetch_req & ofetch_rdy;
  assign fetch_idx = MP_AW'(imem_word_idx(64'(ifetch_addr), MP_AW));

`ifdef IMEM_CTRL_LOADER_EN
  logic [0:0]   state_q, state_d;
  logic [MP_AW:0] wcnt_q, wcnt_d;
  logic         wcnt_full;

  assign load_acc  = (state_q == IMEM_BOOT) & iload_vld;
  assign load_idx  = wcnt_q[MP_AW-1:0];
  assign wcnt_full = (wcnt_q == (MP_AW+1)'(MP_DEPTH - 1));

  // Next state and write counter; reload wins over a concurrent load word
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    if (ireload) begin
      state_d = IMEM_BOOT;
      wcnt_d  = '0;
    end else if (load_acc) begin
      wcnt_d = wcnt_q + 1'b1;
      if (iload_last || wcnt_full) state_d = IMEM_RUN;
    end
  end

  // FSM and counter registers
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state_q <= IMEM_BOOT;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  assign obooted    = (state_q == IMEM_RUN);
  assign ofetch_rdy = (state_q == IMEM_RUN);
  assign oload_rdy  = (state_q == IMEM_BOOT);
  assign oload_cnt  = wcnt_q;
`else
  // Loader inputs have no effect in this build
  logic unused_loader;
  assign unused_loader = ^{iload_vld, iload_data, iload_last, ireload};

  assign load_acc   = 1'b0;
  assign load_idx   = '0;
  assign obooted    = 1'b1;
  assign ofetch_rdy = 1'b1;
  assign oload_rdy  = 1'b0;
  assign oload_cnt  = '0;
`endif

  // RAM port: loader write or fetch read, never both in the same state
  always_comb begin
    omem_en    = 1'b0;
    omem_we    = 1'b0;
    omem_addr  = '0;
    omem_wdata = '0;
    if (load_acc) begin
      omem_en    = 1'b1;
      omem_we    = 1'b1;
      omem_addr  = load_idx;
      omem_wdata = iload_data;
    end else if (fetch_acc) begin
      omem_en   = 1'b1;
      omem_addr = fetch_idx;
    end
  end

  // Read-valid pipeline; misaligned reads still return data but are flagged
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      fetch_vld_q <= 1'b0;
      fetch_err_q <= 1'b0;
    end else begin
      fetch_vld_q <= fetch_acc;
      fetch_err_q <= fetch_acc & (ifetch_addr[1:0] != 2'b00);
    end
  end

  assign ofetch_vld  = fetch_vld_q;
  assign ofetch_err  = fetch_err_q;
  assign ofetch_data = imem_rdata;

endmodule

// File: tb/tb_imem_ctrl.sv
// Scoreboard bench for imem_ctrl with a behavioural RAM and reference model.
// Works with or without IMEM_CTRL_LOADER_EN defined.
module tb_imem_ctrl;

  localparam int DEPTH = 256;
  localparam int AW    = 8;
`ifdef IMEM_CTRL_LOADER_EN
  localparam bit LOADER = 1'b1;
`else
  localparam bit LOADER = 1'b0;
`endif

  logic          iclk = 1'b0;
  logic          irst_n;
  logic          ifetch_req;
  logic [31:0]   ifetch_addr;
  logic          ofetch_rdy, ofetch_vld, ofetch_err;
  logic [31:0]   ofetch_data;
  logic          iload_vld, iload_last;
  logic [31:0]   iload_data;
  logic          oload_rdy;
  logic [AW:0]   oload_cnt;
  logic          ireload;
  logic          obooted;
  logic          omem_en, omem_we;
  logic [AW-1:0] omem_addr;
  logic [31:0]   omem_wdata;
  logic [31:0]   imem_rdata;

  imem_ctrl #(.MP_WIDTH(32), .MP_DEPTH(DEPTH)) dut (
    .iclk(iclk), .irst_n(irst_n),
    .ifetch_req(ifetch_req), .ifetch_addr(ifetch_addr),
    .ofetch_rdy(ofetch_rdy), .ofetch_vld(ofetch_vld),
    .ofetch_data(ofetch_data), .ofetch_err(ofetch_err),
    .iload_vld(iload_vld), .iload_data(iload_data), .iload_last(iload_last),
    .oload_rdy(oload_rdy), .oload_cnt(oload_cnt),
    .ireload(ireload), .obooted(obooted),
    .omem_en(omem_en), .omem_we(omem_we), .omem_addr(omem_addr),
    .omem_wdata(omem_wdata), .imem_rdata(imem_rdata)
  );

  always #5 iclk = ~iclk;

  // Behavioural single-port RAM with a bench-side preload port
  logic [31:0] ram [DEPTH];
  logic        pre_we = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [31:0] pre_data = '0;
  always @(posedge iclk) begin
    if (pre_we) ram[pre_addr] <= pre_data;
    else if (omem_en) begin
      if (omem_we) ram[omem_addr] <= omem_wdata;
      else imem_rdata <= ram[omem_addr];
    end
  end

  // Reference model: intended RAM contents, boot flag, words loaded
  logic [31:0] ref_mem [DEPTH];
  bit          m_booted;
  int          m_wcnt;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: every valid fetch result must match the oldest expectation
  always @(negedge iclk) begin
    if (irst_n && ofetch_vld) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_vld: got data 0x%0h with no outstanding fetch", ofetch_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("fetch_data", 64'(ofetch_data), 64'(e.data));
        check("fetch_err", 64'(ofetch_err), 64'(e.err));
      end
    end
  end

  task automatic check_status(input string tag);
    check({tag, "_booted"}, 64'(obooted), 64'(m_booted));
    check({tag, "_fetch_rdy"}, 64'(ofetch_rdy), 64'(m_booted));
    check({tag, "_load_rdy"}, 64'(oload_rdy), 64'(LOADER && !m_booted));
    check({tag, "_load_cnt"}, 64'(oload_cnt), 64'(m_wcnt));
  endtask

  // One clock of stimulus; returns 1 time unit after the rising edge
  task automatic drive_cycle(input logic req, input logic [31:0] addr, input logic lvld,
                             input logic [31:0] ldata, input logic llast, input logic rel);
    bit facc, lacc;
    int idx;
    ifetch_req = req; ifetch_addr = addr;
    iload_vld = lvld; iload_data = ldata; iload_last = llast; ireload = rel;
    #1;
    facc = req && m_booted;
    lacc = LOADER && lvld && !m_booted;
    idx  = int'((addr >> 2) % DEPTH);
    check("mem_en", 64'(omem_en), 64'(facc || lacc));
    check("mem_we", 64'(omem_we), 64'(lacc));
    if (lacc) begin
      check("mem_waddr", 64'(omem_addr), 64'(m_wcnt));
      check("mem_wdata", 64'(omem_wdata), 64'(ldata));
      ref_mem[m_wcnt] = ldata;
    end
    if (facc) begin
      check("mem_raddr", 64'(omem_addr), 64'(idx));
      sb.push_back('{ref_mem[idx], addr[1:0] != 2'b00});
    end
    @(posedge iclk);
    if (LOADER && rel) begin
      m_booted = 1'b0;
      m_wcnt   = 0;
    end else if (lacc) begin
      m_wcnt++;
      if (llast || m_wcnt == DEPTH) m_booted = 1'b1;
    end
    #1;
    check_status("cyc");
  endtask

  task automatic idle();
    drive_cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic random_fetches(input int n);
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      drive_cycle($urandom_range(0, 3) != 0, a, 1'(($urandom_range(0, 1))), $urandom,
                  1'($urandom_range(0, 1)), LOADER ? 1'b0 : 1'($urandom_range(0, 7) == 0));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] boot_words [3];
    logic [31:0] w;
    int          i;
    boot_words[0] = 32'h0050_0113;
    boot_words[1] = 32'h00C0_0193;
    boot_words[2] = 32'hFF71_8393;

    irst_n = 1'b0;
    ifetch_req = 1'b0; ifetch_addr = '0;
    iload_vld = 1'b0; iload_data = '0; iload_last = 1'b0; ireload = 1'b0;
    m_booted = !LOADER;
    m_wcnt = 0;
    for (int k = 0; k < DEPTH; k++) ref_mem[k] = '0;

    // Preload the RAM (also gives the loader-enabled build defined contents)
    for (int k = 0; k < DEPTH; k++) begin
      @(negedge iclk);
      pre_we = 1'b1; pre_addr = AW'(k); pre_data = LOADER ? 32'h0 : $urandom;
      ref_mem[k] = pre_data;
    end
    @(negedge iclk);
    pre_we = 1'b0;

    check("rst_fetch_vld", 64'(ofetch_vld), 64'd0);
    check("rst_fetch_err", 64'(ofetch_err), 64'd0);
    check_status("rst");
    @(negedge iclk);
    irst_n = 1'b1;
    @(posedge iclk);
    #1;
    check_status("post_rst");

    if (LOADER) begin
      // Three-word boot, last flagged on the third word
      for (int k = 0; k < 3; k++)
        drive_cycle(1'b0, 32'h0, 1'b1, boot_words[k], k == 2, 1'b0);
      check("boot_cnt", 64'(oload_cnt), 64'd3);
      check("boot_done", 64'(obooted), 64'd1);
    end else begin
      for (int k = 0; k < 3; k++) ref_mem[k] = ref_mem[k];
    end

    // Back-to-back aligned fetches, then a misaligned one
    drive_cycle(1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    drive_cycle(1'b1, 32'h4, 1'b0, 32'h0, 1'b0, 1'b0);
    drive_cycle(1'b1, 32'h8, 1'b0, 32'h0, 1'b0, 1'b0);
    drive_cycle(1'b1, 32'h6, 1'b0, 32'h0, 1'b0, 1'b0);
    idle();
    random_fetches(200);
    idle();

    if (LOADER) begin
      // Reload alongside a fetch: the fetch completes, controller returns to boot
      drive_cycle(1'b1, 32'h4, 1'b0, 32'h0, 1'b0, 1'b1);
      check("reload_cnt", 64'(oload_cnt), 64'd0);
      check("reload_rdy", 64'(ofetch_rdy), 64'd0);
      idle();

      // Full-depth stream without last: auto-transition, no wrap
      i = 0;
      while (i < DEPTH) begin
        if ($urandom_range(0, 3) == 0)
          drive_cycle(1'($urandom_range(0, 1)), $urandom, 1'b0, 32'h0, 1'b0, 1'b0);
        w = $urandom;
        drive_cycle(1'($urandom_range(0, 1)), $urandom, 1'b1, w, 1'b0, 1'b0);
        i++;
      end
      check("full_cnt", 64'(oload_cnt), 64'(DEPTH));
      check("full_booted", 64'(obooted), 64'd1);
      for (int k = 0; k < 3; k++)
        drive_cycle(1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
      check("run_cnt_hold", 64'(oload_cnt), 64'(DEPTH));
      drive_cycle(1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      idle();
      random_fetches(150);
      idle();
    end

    // Asynchronous reset in the cycle after an accepted fetch
    drive_cycle(1'b1, 32'h8, 1'b0, 32'h0, 1'b0, 1'b0);
    irst_n = 1'b0;
    sb.delete();
    #1;
    check("async_rst_vld", 64'(ofetch_vld), 64'd0);
    m_booted = !LOADER;
    m_wcnt   = 0;
    ifetch_req = 1'b0; iload_vld = 1'b0; ireload = 1'b0;
    @(negedge iclk);
    irst_n = 1'b1;
    @(posedge iclk);
    #1;
    check_status("rst2");
    idle();
    idle();
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
